// File: rtl/bio_debounce.sv
// Button/switch debouncer with a 4-word register port: synchronise, sample on a divided tick,
// commit after STABLE_CNT differing samples, latch change events and raise a maskable level irq.
module bio_debounce #(
  parameter int N_IN       = 21,
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] raw_in,
  input  logic            en,
  input  logic            wr,
  input  logic [1:0]      addr,
  input  logic [31:0]     din,
  output logic [31:0]     dout,
  output logic            irq
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CNT - 1);
  // Register bits at or above N_IN are forced to zero through this mask.
  localparam logic [31:0] VALID = (N_IN >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << N_IN) - 64'd1);

  logic [N_IN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [CW-1:0]   cnt_q [N_IN];
  logic [CW-1:0]   cnt_d [N_IN];
  logic [N_IN-1:0] state_q, state_d;
  logic [31:0]     event_q, event_d, mask_q, mask_d;
  logic [31:0]     set_vec, w1c_vec;
  logic            irq_q, irq_d;
  logic            tick, wr_event, wr_mask;

  always_comb begin
    sync1_d    = raw_in;
    sync2_d    = sync1_q;
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    state_d    = state_q;
    set_vec    = '0;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] == state_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          state_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
          set_vec[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    wr_event = en & wr & (addr == 2'd1);
    wr_mask  = en & wr & (addr == 2'd2);
    w1c_vec  = wr_event ? (din & VALID) : '0;
    // A fresh commit beats a simultaneous write-one-to-clear.
    event_d  = (event_q & ~w1c_vec) | set_vec;
    mask_d   = wr_mask ? (din & VALID) : mask_q;
    irq_d    = |(event_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      state_q    <= '0;
      event_q    <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      event_q    <= event_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      2'd0: dout[N_IN-1:0] = state_q;
      2'd1: dout = event_q;
      2'd2: dout = mask_q;
      default: begin
        dout[0] = irq_q;
        dout[1] = tick;
      end
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_bio_debounce.sv
// Bench for bio_debounce: register table, hand-timed corner sequences and a randomized run,
// all checked against a behavioural model of the debounce and register rules.
module tb_bio_debounce;

  localparam int N_IN       = 21;
  localparam int TICK_DIV   = 4;
  localparam int STABLE_CNT = 3;
  localparam logic [31:0] VMASK = 32'h001F_FFFF;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_IN-1:0] raw_in = '0;
  logic            en = 1'b0;
  logic            wr = 1'b0;
  logic [1:0]      addr = 2'd0;
  logic [31:0]     din = '0;
  logic [31:0]     dout;
  logic            irq;

  int n_chk = 0;
  int n_fail = 0;

  bio_debounce #(.N_IN(N_IN), .TICK_DIV(TICK_DIV), .STABLE_CNT(STABLE_CNT)) dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .en(en), .wr(wr),
    .addr(addr), .din(din), .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: sync is the raw value from two edges back, ticks fall on every
  // TICK_DIV-th edge since reset, a level commits after STABLE_CNT consecutive differing samples.
  logic [N_IN-1:0] m_state;
  logic [31:0]     m_event, m_mask;
  logic            m_irq;
  logic [N_IN-1:0] m_pipe[$];
  int              m_run[N_IN];
  int              m_edges;
  bit              m_ok = 1'b0;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0: v[N_IN-1:0] = m_state;
      2'd1: v = m_event;
      2'd2: v = m_mask;
      default: begin
        v[0] = m_irq;
        v[1] = ((m_edges % TICK_DIV) == TICK_DIV - 1);
      end
    endcase
    return v;
  endfunction

  always @(posedge clk) begin : model
    logic [N_IN-1:0] s;
    logic [31:0]     set_v;
    logic            irq_n;
    bit              tk;
    if (!rst_n) begin
      m_state = '0;
      m_event = '0;
      m_mask  = '0;
      m_irq   = 1'b0;
      m_pipe.delete();
      m_pipe.push_back('0);
      m_pipe.push_back('0);
      for (int i = 0; i < N_IN; i++) m_run[i] = 0;
      m_edges = 0;
      m_ok    = 1'b1;
    end else if (m_ok) begin
      tk = ((m_edges % TICK_DIV) == TICK_DIV - 1);
      m_edges++;
      s = m_pipe.pop_front();
      m_pipe.push_back(raw_in);
      set_v = '0;
      irq_n = |(m_event & m_mask);
      if (tk) begin
        for (int i = 0; i < N_IN; i++) begin
          if (s[i] != m_state[i]) begin
            m_run[i]++;
            if (m_run[i] == STABLE_CNT) begin
              m_state[i] = s[i];
              set_v[i]   = 1'b1;
              m_run[i]   = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      if (en && wr && addr == 2'd1) m_event = m_event & ~(din & VMASK);
      m_event = m_event | set_v;
      if (en && wr && addr == 2'd2) m_mask = din & VMASK;
      m_irq = irq_n;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Lockstep scoreboard on whatever address the stimulus currently drives.
  always @(posedge clk) begin
    #2;
    if (m_ok) begin
      chk("lockstep_dout", dout, m_read(addr));
      chk("lockstep_irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, dout, exp);
  endtask

  task automatic irq_chk(input string name, input logic exp);
    chk(name, {31'd0, irq}, {31'd0, exp});
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    en = 1'b1; wr = 1'b1; addr = a; din = d;
    @(negedge clk);
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic wait_bit(input string name, input logic [1:0] a, input int b, input logic lvl);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      addr = a;
      #1;
      if (dout[b] === lvl) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  typedef struct {
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit found;
    logic [N_IN-1:0] p0;

    vecs[0] = '{2'd2, 32'hFFFF_FFFF, 2'd2, 32'h001F_FFFF};
    vecs[1] = '{2'd2, 32'h0000_0000, 2'd2, 32'h0000_0000};
    vecs[2] = '{2'd2, 32'h1234_5678, 2'd2, 32'h0014_5678};
    vecs[3] = '{2'd0, 32'hFFFF_FFFF, 2'd0, 32'h0000_0000};
    vecs[4] = '{2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0000_0000};
    vecs[5] = '{2'd3, 32'hFFFF_FFFF, 2'd2, 32'h0014_5678};
    vecs[6] = '{2'd2, 32'h0000_0000, 2'd2, 32'h0000_0000};

    // Reset values while rst_n is held low.
    repeat (3) @(negedge clk);
    rd_chk("reset_state", 2'd0, 32'd0);
    rd_chk("reset_event", 2'd1, 32'd0);
    rd_chk("reset_mask", 2'd2, 32'd0);
    rd_chk("reset_status", 2'd3, 32'd0);
    irq_chk("reset_irq", 1'b0);
    rst_n = 1'b1;

    // Register access table with quiet inputs.
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      bus_wr(vecs[i].wa, vecs[i].wd);
      rd_chk($sformatf("table_%0d", i), vecs[i].ra, vecs[i].exp);
      irq_chk($sformatf("table_irq_%0d", i), 1'b0);
    end

    // Key 0 press held: commit and event, no irq while masked off.
    @(negedge clk);
    raw_in[0] = 1'b1;
    wait_bit("commit0_in_time", 2'd0, 0, 1'b1);
    rd_chk("commit0_state", 2'd0, 32'h1);
    rd_chk("commit0_event", 2'd1, 32'h1);
    @(negedge clk);
    irq_chk("commit0_irq_masked", 1'b0);

    // Short glitch on input 5 must not commit.
    raw_in[5] = 1'b1;
    repeat (5) @(negedge clk);
    raw_in[5] = 1'b0;
    repeat (20) @(negedge clk);
    rd_chk("glitch5_state", 2'd0, 32'h1);
    rd_chk("glitch5_event", 2'd1, 32'h1);

    // Masked event raises irq one clock after EVENT sets; W1C drops it one clock later.
    bus_wr(2'd1, 32'h1);
    bus_wr(2'd2, 32'h1);
    irq_chk("irq_idle", 1'b0);
    raw_in[0] = 1'b0;
    wait_bit("release0_in_time", 2'd1, 0, 1'b1);
    irq_chk("irq_lag", 1'b0);
    @(negedge clk);
    irq_chk("irq_raised", 1'b1);
    bus_wr(2'd1, 32'h1);
    rd_chk("w1c_event", 2'd1, 32'h0);
    irq_chk("irq_before_drop", 1'b1);
    @(negedge clk);
    irq_chk("irq_dropped", 1'b0);

    // W1C of EVENT[2] on the very edge where bit 2 commits again.
    bus_wr(2'd2, 32'h4);
    raw_in[2] = 1'b1;
    wait_bit("commit2_in_time", 2'd1, 2, 1'b1);
    @(negedge clk);
    raw_in[2] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      p0 = m_pipe[0];
      if (((m_edges % TICK_DIV) == TICK_DIV - 1) && (p0[2] != m_state[2]) &&
          (m_run[2] == STABLE_CNT - 1)) begin
        en = 1'b1; wr = 1'b1; addr = 2'd1; din = 32'h4;
        found = 1'b1;
        break;
      end
    end
    chk("collide_found", {31'd0, found}, 32'd1);
    @(negedge clk);
    en = 1'b0; wr = 1'b0;
    rd_chk("collide_state", 2'd0, 32'h0);
    rd_chk("collide_event", 2'd1, 32'h4);
    irq_chk("collide_irq", 1'b1);
    @(negedge clk);
    irq_chk("collide_irq_held", 1'b1);

    // Reset in the middle of a count on input 20.
    bus_wr(2'd2, 32'h0);
    bus_wr(2'd1, VMASK);
    raw_in[20] = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_run[20] == 1) begin
        found = 1'b1;
        break;
      end
    end
    chk("midcount_found", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("midrst_state", 2'd0, 32'd0);
    rd_chk("midrst_event", 2'd1, 32'd0);
    rd_chk("midrst_mask", 2'd2, 32'd0);
    rd_chk("midrst_status", 2'd3, 32'd0);
    irq_chk("midrst_irq", 1'b0);
    repeat (11) @(negedge clk);
    rd_chk("midrst_not_yet", 2'd0, 32'd0);
    @(negedge clk);
    rd_chk("midrst_commit_state", 2'd0, 32'h0010_0000);
    rd_chk("midrst_commit_event", 2'd1, 32'h0010_0000);

    // Randomized traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      for (int b = 0; b < N_IN; b++) begin
        if ($urandom_range(0, 39) == 0) raw_in[b] = ~raw_in[b];
      end
      en    = $urandom_range(0, 1) == 1;
      wr    = $urandom_range(0, 3) == 0;
      addr  = 2'($urandom_range(0, 3));
      din   = $urandom;
      rst_n = $urandom_range(0, 499) != 0;
    end
    @(negedge clk);
    en = 1'b0; wr = 1'b0; rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "timeout");
  end

endmodule
